// File: rtl/linear_pkg.sv
// Shared types and width defaults for the linear layer arbiter.
//   lla_state_t    : arbiter FSM state encoding
//   DEF_IN_DATA_W  : default signed input element width
//   DEF_ACC_W      : default layer accumulator width
//   DEF_OUT_DATA_W : default output element width (full accumulator)
package linear_pkg;

    localparam int unsigned DEF_IN_DATA_W  = 8;
    localparam int unsigned DEF_ACC_W      = 32;
    localparam int unsigned DEF_OUT_DATA_W = DEF_ACC_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } lla_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first asserted request at or after rr_ptr, circularly.
// Purely combinational.
//   req      : per-requester request levels
//   rr_ptr   : index that has highest priority this round
//   pick_idx : index of the chosen requester (valid when pick_vld)
//   pick_vld : at least one request is asserted
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [IDX_W-1:0] pick_idx,
    output logic             pick_vld
);

    localparam logic [IDX_W:0] N_REQ_V = (IDX_W + 1)'(N_REQ);

    logic [N_REQ-1:0] req_rot;
    logic [IDX_W-1:0] rot_idx;
    logic [IDX_W:0]   idx_sum;

    always_comb begin
        // Rotate so rr_ptr lands on bit 0, then the lowest set bit wins.
        req_rot = N_REQ'({req, req} >> rr_ptr);
        rot_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                rot_idx = IDX_W'(i);
            end
        end
        // Rotate back: (rot_idx + rr_ptr) mod N_REQ.
        idx_sum = {1'b0, rot_idx} + {1'b0, rr_ptr};
        if (idx_sum >= N_REQ_V) begin
            idx_sum = idx_sum - N_REQ_V;
        end
        pick_idx = idx_sum[IDX_W-1:0];
        pick_vld = |req;
    end

endmodule

// File: rtl/linear_layer_arbiter.sv
// Shares one linear layer between N_REQ requesters with round-robin arbitration.
// Drives the layer start/done level handshake, muxes the winner's input vector
// onto the layer, captures the layer result and returns it to the winner with a
// one-cycle resp_valid pulse.
//
// Optional feature: define LLA_WATCHDOG_EN to enable a run-time watchdog that
// aborts a job after TIMEOUT_CYC cycles in S_RUN, sets sticky err and pulses
// ll_rst for two cycles.
//
// Ports:
//   clk        : clock, rising edge
//   rst_n      : synchronous active-low reset
//   req        : per-requester request level
//   x_req      : per-requester input vectors (signed elements)
//   grant      : one-hot owner of the layer, zero when idle
//   resp_valid : one-cycle pulse to the owner when y_resp is valid
//   y_resp     : captured layer result, held until the next capture
//   busy       : FSM not idle
//   err        : sticky watchdog error (0 without LLA_WATCHDOG_EN)
//   ll_rst     : active-high layer reset (registered ~rst_n or watchdog pulse)
//   ll_start   : layer start level
//   ll_x       : input vector of the current owner
//   ll_y       : layer output vector
//   ll_done    : layer done level
module linear_layer_arbiter
    import linear_pkg::*;
#(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned IN_DIM      = 64,
    parameter int unsigned OUT_DIM     = 8,
    parameter int unsigned IN_DATA_W   = DEF_IN_DATA_W,
    parameter int unsigned OUT_DATA_W  = DEF_OUT_DATA_W,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic [N_REQ-1:0]                            req,
    input  logic [N_REQ-1:0][IN_DIM-1:0][IN_DATA_W-1:0] x_req,
    output logic [N_REQ-1:0]                            grant,
    output logic [N_REQ-1:0]                            resp_valid,
    output logic [OUT_DIM-1:0][OUT_DATA_W-1:0]          y_resp,
    output logic                                        busy,
    output logic                                        err,
    output logic                                        ll_rst,
    output logic                                        ll_start,
    output logic [IN_DIM-1:0][IN_DATA_W-1:0]            ll_x,
    input  logic [OUT_DIM-1:0][OUT_DATA_W-1:0]          ll_y,
    input  logic                                        ll_done
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    lla_state_t                         state_q, state_d;
    logic [N_REQ-1:0]                   grant_q, grant_d;
    logic [IDX_W-1:0]                   gnt_idx_q, gnt_idx_d;
    logic [IDX_W-1:0]                   rr_ptr_q, rr_ptr_d;
    logic                               ll_start_q, ll_start_d;
    logic [N_REQ-1:0]                   resp_valid_q, resp_valid_d;
    logic [OUT_DIM-1:0][OUT_DATA_W-1:0] y_resp_q, y_resp_d;
    logic                               ll_rst_q;

    logic [IDX_W-1:0]                   pick_idx;
    logic                               pick_vld;

`ifdef LLA_WATCHDOG_EN
    logic [31:0] wd_cnt_q, wd_cnt_d;
    logic [1:0]  wd_pulse_q, wd_pulse_d;
    logic        err_q, err_d;
    logic        wd_fire;

    // The counter reaches TIMEOUT_CYC on the edge where this is true.
    assign wd_fire = (wd_cnt_q == 32'(TIMEOUT_CYC - 1));
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYC;
`endif

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req      (req),
        .rr_ptr   (rr_ptr_q),
        .pick_idx (pick_idx),
        .pick_vld (pick_vld)
    );

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        gnt_idx_d    = gnt_idx_q;
        rr_ptr_d     = rr_ptr_q;
        ll_start_d   = ll_start_q;
        resp_valid_d = '0;
        y_resp_d     = y_resp_q;
`ifdef LLA_WATCHDOG_EN
        wd_cnt_d     = wd_cnt_q;
        wd_pulse_d   = (wd_pulse_q != 2'd0) ? wd_pulse_q - 2'd1 : 2'd0;
        err_d        = err_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    gnt_idx_d         = pick_idx;
                    ll_start_d        = 1'b1;
                    state_d           = S_RUN;
`ifdef LLA_WATCHDOG_EN
                    wd_cnt_d          = '0;
`endif
                end
            end

            S_RUN: begin
`ifdef LLA_WATCHDOG_EN
                wd_cnt_d = wd_cnt_q + 32'd1;
`endif
                if (ll_done) begin
                    y_resp_d = ll_y;
                    // A requester that dropped req mid-job gets no pulse.
                    resp_valid_d[gnt_idx_q] = req[gnt_idx_q];
                    ll_start_d = 1'b0;
                    state_d    = S_DRAIN;
                end
`ifdef LLA_WATCHDOG_EN
                else if (wd_fire) begin
                    err_d      = 1'b1;
                    wd_pulse_d = 2'd2;
                    ll_start_d = 1'b0;
                    state_d    = S_DRAIN;
                end
`endif
            end

            S_DRAIN: begin
                // Grant is held until the layer has cleared done, which also
                // keeps the grant drop at least one cycle after resp_valid.
                if (!ll_done) begin
                    grant_d  = '0;
                    rr_ptr_d = (gnt_idx_q == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx_q + 1'b1;
                    state_d  = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        ll_rst_q <= ~rst_n;
        if (!rst_n) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            gnt_idx_q    <= '0;
            rr_ptr_q     <= '0;
            ll_start_q   <= 1'b0;
            resp_valid_q <= '0;
            y_resp_q     <= '0;
`ifdef LLA_WATCHDOG_EN
            wd_cnt_q     <= '0;
            wd_pulse_q   <= 2'd0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            gnt_idx_q    <= gnt_idx_d;
            rr_ptr_q     <= rr_ptr_d;
            ll_start_q   <= ll_start_d;
            resp_valid_q <= resp_valid_d;
            y_resp_q     <= y_resp_d;
`ifdef LLA_WATCHDOG_EN
            wd_cnt_q     <= wd_cnt_d;
            wd_pulse_q   <= wd_pulse_d;
            err_q        <= err_d;
`endif
        end
    end

    assign grant      = grant_q;
    assign resp_valid = resp_valid_q;
    assign y_resp     = y_resp_q;
    assign busy       = (state_q != S_IDLE);
    assign ll_start   = ll_start_q;
    assign ll_x       = x_req[gnt_idx_q];

`ifdef LLA_WATCHDOG_EN
    assign err    = err_q;
    assign ll_rst = ll_rst_q | (wd_pulse_q != 2'd0);
`else
    assign err    = 1'b0;
    assign ll_rst = ll_rst_q;
`endif

endmodule

// File: tb/tb_linear_layer_arbiter.sv
// Directed bench for linear_layer_arbiter with a behavioural layer model
// (12-cycle latency, y[j] = sum(x) + j) and a response scoreboard.
module tb_linear_layer_arbiter;

    localparam int N_REQ   = 4;
    localparam int IN_DIM  = 4;
    localparam int OUT_DIM = 8;
    localparam int IN_W    = 8;
    localparam int OUT_W   = 32;
    localparam int LAT     = 12;
    localparam int TO_CYC  = 20;
    localparam int CW      = OUT_DIM * OUT_W;

    logic                                   clk;
    logic                                   rst_n;
    logic [N_REQ-1:0]                       req;
    logic [N_REQ-1:0][IN_DIM-1:0][IN_W-1:0] x_req;
    logic [N_REQ-1:0]                       grant;
    logic [N_REQ-1:0]                       resp_valid;
    logic [OUT_DIM-1:0][OUT_W-1:0]          y_resp;
    logic                                   busy;
    logic                                   err;
    logic                                   ll_rst;
    logic                                   ll_start;
    logic [IN_DIM-1:0][IN_W-1:0]            ll_x;
    logic [OUT_DIM-1:0][OUT_W-1:0]          ll_y;
    logic                                   ll_done;

    linear_layer_arbiter #(
        .N_REQ       (N_REQ),
        .IN_DIM      (IN_DIM),
        .OUT_DIM     (OUT_DIM),
        .IN_DATA_W   (IN_W),
        .OUT_DATA_W  (OUT_W),
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .x_req      (x_req),
        .grant      (grant),
        .resp_valid (resp_valid),
        .y_resp     (y_resp),
        .busy       (busy),
        .err        (err),
        .ll_rst     (ll_rst),
        .ll_start   (ll_start),
        .ll_x       (ll_x),
        .ll_y       (ll_y),
        .ll_done    (ll_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural layer model ----------------
    logic                          m_busy, m_done, m_hang;
    int                            m_cnt, m_clr, m_sum;
    logic [OUT_DIM-1:0][OUT_W-1:0] m_y;

    function automatic int vec_sum(input logic [IN_DIM-1:0][IN_W-1:0] v);
        int s;
        s = 0;
        for (int k = 0; k < IN_DIM; k++) s += int'($signed(v[k]));
        return s;
    endfunction

    always @(posedge clk) begin
        if (ll_rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_cnt  <= 0;
            m_clr  <= 0;
        end else if (m_done) begin
            // done clears two cycles after start is seen low
            if (!ll_start) begin
                if (m_clr == 1) begin
                    m_done <= 1'b0;
                    m_clr  <= 0;
                end else begin
                    m_clr <= m_clr + 1;
                end
            end
        end else if (m_busy) begin
            if (m_cnt == LAT - 1 && !m_hang) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                for (int j = 0; j < OUT_DIM; j++) m_y[j] <= OUT_W'(m_sum + j);
            end else if (m_cnt < LAT) begin
                m_cnt <= m_cnt + 1;
            end
        end else if (ll_start) begin
            m_busy <= 1'b1;
            m_cnt  <= 0;
            m_sum  <= vec_sum(ll_x);
        end
    end

    assign ll_done = m_done;
    assign ll_y    = m_y;

    // ---------------- scoreboard ----------------
    typedef struct {
        int              idx;
        logic [CW-1:0]   y;
    } exp_t;

    exp_t sb[$];

    function automatic logic [OUT_DIM-1:0][OUT_W-1:0] exp_y(input int idx);
        logic [OUT_DIM-1:0][OUT_W-1:0] r;
        int s;
        s = 0;
        for (int k = 0; k < IN_DIM; k++) s += int'($signed(x_req[idx][k]));
        for (int j = 0; j < OUT_DIM; j++) r[j] = OUT_W'(s + j);
        return r;
    endfunction

    task automatic push(input int idx);
        exp_t e;
        e.idx = idx;
        e.y   = exp_y(idx);
        sb.push_back(e);
    endtask

    task automatic set_x(input int idx, input int base, input int step);
        for (int k = 0; k < IN_DIM; k++) x_req[idx][k] = IN_W'(base + k * step);
    endtask

    logic             mon_en;
    exp_t             mon_e;
    logic [N_REQ-1:0] mon_oh;
    logic [N_REQ-1:0] grant_prev, resp_prev;

    always @(negedge clk) begin
        if (mon_en) begin
            check("grant_onehot0", CW'($onehot0(grant)), CW'(1));
            if (resp_valid != '0) begin
                if (sb.size() == 0) begin
                    check("resp_unexpected", CW'(resp_valid), CW'(0));
                end else begin
                    mon_e  = sb.pop_front();
                    mon_oh = '0;
                    mon_oh[mon_e.idx] = 1'b1;
                    check("resp_who", CW'(resp_valid), CW'(mon_oh));
                    check("resp_y", CW'(y_resp), mon_e.y);
                    check("resp_owner", CW'(resp_valid & ~grant), CW'(0));
                end
            end
            if (grant_prev != '0 && grant == '0) begin
                check("grant_drop_vs_pulse", CW'({resp_prev, resp_valid}), CW'(0));
            end
        end
        grant_prev <= grant;
        resp_prev  <= resp_valid;
    end

    // ---------------- bounded waits ----------------
    task automatic wait_resp(output logic [N_REQ-1:0] who);
        logic found;
        found = 1'b0;
        who   = '0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            if (resp_valid != '0) begin
                found = 1'b1;
                who   = resp_valid;
            end
        end
        check("resp_wait", CW'(found), CW'(1));
    endtask

    task automatic wait_idle();
        logic found;
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            if (!busy) found = 1'b1;
        end
        check("idle_wait", CW'(found), CW'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "bench time limit");
    end

    // ---------------- directed sequence ----------------
    logic [N_REQ-1:0] who;
    int               k_run;
    logic             seen;

    initial begin
        rst_n  = 1'b0;
        req    = '0;
        x_req  = '0;
        m_hang = 1'b0;
        mon_en = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_grant", CW'(grant), CW'(0));
        check("rst_resp_valid", CW'(resp_valid), CW'(0));
        check("rst_y_resp", CW'(y_resp), CW'(0));
        check("rst_ll_start", CW'(ll_start), CW'(0));
        check("rst_busy", CW'(busy), CW'(0));
        check("rst_err", CW'(err), CW'(0));
        check("rst_ll_rst", CW'(ll_rst), CW'(1));
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_release_ll_rst", CW'(ll_rst), CW'(0));
        mon_en = 1'b1;

        // 1: single request
        set_x(1, 3, 0);
        push(1);
        req = 4'b0010;
        @(negedge clk);
        check("t1_grant", CW'(grant), CW'(4'b0010));
        check("t1_busy", CW'(busy), CW'(1));
        check("t1_ll_start", CW'(ll_start), CW'(1));
        check("t1_ll_x", CW'(ll_x), CW'(x_req[1]));
        wait_resp(who);
        req = req & ~who;
        wait_idle();
        check("t1_idle_grant", CW'(grant), CW'(0));
        check("t1_y_held", CW'(y_resp), CW'(exp_y(1)));

        // 2: simultaneous requests from rr_ptr = 0
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        set_x(0, 1, 1);
        set_x(1, -1, -1);
        set_x(2, 100, 10);
        set_x(3, -128, 0);
        for (int i = 0; i < N_REQ; i++) push(i);
        req = 4'b1111;
        for (int i = 0; i < N_REQ; i++) begin
            wait_resp(who);
            req = req & ~who;
        end
        wait_idle();
        check("t2_sb_drained", CW'(sb.size()), CW'(0));

        // 3: fairness, requester 0 re-requests right after service
        set_x(0, 5, 2);
        set_x(2, -7, 3);
        push(0);
        push(2);
        req = 4'b0101;
        wait_resp(who);
        req = req & ~who;
        @(negedge clk);
        set_x(0, 9, 1);
        push(0);
        req[0] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wait_resp(who);
            req = req & ~who;
        end
        wait_idle();

        // 4: abort by dropping req mid-run
        set_x(3, 20, -3);
        req = 4'b1000;
        @(negedge clk);
        check("t4_grant", CW'(grant), CW'(4'b1000));
        repeat (5) @(negedge clk);
        req = '0;
        wait_idle();
        check("t4_y_updated", CW'(y_resp), CW'(exp_y(3)));
        check("t4_grant_clear", CW'(grant), CW'(0));
        set_x(1, 2, 2);
        push(1);
        req = 4'b0010;
        wait_resp(who);
        req = req & ~who;
        wait_idle();

        // 5: reset during S_RUN
        set_x(2, 11, 0);
        req = 4'b0100;
        @(negedge clk);
        check("t5_grant", CW'(grant), CW'(4'b0100));
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        req   = '0;
        @(negedge clk);
        check("t5_grant_rst", CW'(grant), CW'(0));
        check("t5_resp_rst", CW'(resp_valid), CW'(0));
        check("t5_busy_rst", CW'(busy), CW'(0));
        check("t5_start_rst", CW'(ll_start), CW'(0));
        check("t5_y_rst", CW'(y_resp), CW'(0));
        check("t5_ll_rst", CW'(ll_rst), CW'(1));
        rst_n = 1'b1;
        set_x(0, -2, 1);
        push(0);
        req = 4'b0001;
        wait_resp(who);
        req = req & ~who;
        wait_idle();

        // 6: layer never finishes
        m_hang = 1'b1;
        set_x(1, 4, 4);
        req = 4'b0010;
        @(negedge clk);
        check("t6_grant", CW'(grant), CW'(4'b0010));
`ifdef LLA_WATCHDOG_EN
        k_run = 0;
        seen  = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            k_run++;
            if (err) seen = 1'b1;
        end
        check("t6_err_seen", CW'(seen), CW'(1));
        check("t6_err_cycle", CW'(k_run), CW'(TO_CYC));
        check("t6_ll_rst_1", CW'(ll_rst), CW'(1));
        check("t6_start_low", CW'(ll_start), CW'(0));
        req = '0;
        @(negedge clk);
        check("t6_ll_rst_2", CW'(ll_rst), CW'(1));
        @(negedge clk);
        check("t6_ll_rst_end", CW'(ll_rst), CW'(0));
        wait_idle();
        check("t6_grant_clear", CW'(grant), CW'(0));
        check("t6_err_sticky", CW'(err), CW'(1));
`else
        repeat (60) @(negedge clk);
        check("t6_busy_stuck", CW'(busy), CW'(1));
        check("t6_grant_held", CW'(grant), CW'(4'b0010));
        check("t6_err_zero", CW'(err), CW'(0));
        req = '0;
`endif
        rst_n = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        m_hang = 1'b0;
        @(negedge clk);
        check("t6_err_after_rst", CW'(err), CW'(0));
        check("t6_busy_after_rst", CW'(busy), CW'(0));

        check("sb_empty", CW'(sb.size()), CW'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
